// File: rtl/sat_narrow.sv
// Narrows signed IN_W-bit words to signed OUT_W-bit words (saturate or wrap) behind a
// valid/ready interface with a 2-entry skid buffer and range-violation statistics.
module sat_narrow #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             sat_sticky,
  input  logic             clr_stat
);

  localparam logic [OUT_W-1:0] MaxPos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MaxNeg = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_sat_q, skid_sat_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             sat_sticky_q, sat_sticky_d;

  logic              accept, emit, in_range;
  logic [IN_W-OUT_W:0] upper;
  logic [OUT_W-1:0]  new_data;

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  // In range when every bit from the sign down to the new sign position agrees.
  always_comb begin
    upper    = in_data[IN_W-1:OUT_W-1];
    in_range = (&upper) || !(|upper);
    new_data = in_data[OUT_W-1:0];
    if (!in_range && sat_en) begin
      new_data = in_data[IN_W-1] ? MaxNeg : MaxPos;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sat_d   = skid_sat_q;
    if (skid_valid_q) begin
      // in_ready is low while skid is full, so only a drain can happen here.
      if (emit) begin
        out_data_d   = skid_data_q;
        out_sat_d    = skid_sat_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || emit) begin
        out_valid_d = 1'b1;
        out_data_d  = new_data;
        out_sat_d   = !in_range;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = new_data;
        skid_sat_d   = !in_range;
      end
    end else if (emit) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    sat_cnt_d    = sat_cnt_q;
    sat_sticky_d = sat_sticky_q;
    if (clr_stat) begin
      sat_cnt_d    = (accept && !in_range) ? CNT_W'(1) : '0;
      sat_sticky_d = accept && !in_range;
    end else if (accept && !in_range) begin
      sat_sticky_d = 1'b1;
      if (sat_cnt_q != CntMax) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sat_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      sat_cnt_q    <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sat_q   <= skid_sat_d;
      in_ready_q   <= in_ready_d;
      sat_cnt_q    <= sat_cnt_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sat_cnt    = sat_cnt_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_sat_narrow.sv
// Directed bench for sat_narrow: narrowing, statistics, skid back-pressure, reset and
// streaming, with hand-computed expectations.
module tb_sat_narrow;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sat_en;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       out_sat;
  logic [7:0] sat_cnt;
  logic       sat_sticky;
  logic       clr_stat;

  int vectors = 0;
  int miscompares = 0;

  sat_narrow #(.IN_W(8), .OUT_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_cnt    (sat_cnt),
    .sat_sticky (sat_sticky),
    .clr_stat   (clr_stat)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    sat_en   = s;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_d;
    logic       exp_s;
    int         v;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; sat_en = 1'b1;
    out_ready = 1'b1; clr_stat = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_sticky", sat_sticky, 0);

    // In-range words, saturate mode.
    send(8'h01, 1'b1);
    chk("t1_v0", out_valid, 1); chk("t1_d0", out_data, 2'b01); chk("t1_s0", out_sat, 0);
    send(8'hFE, 1'b1);
    chk("t1_d1", out_data, 2'b10); chk("t1_s1", out_sat, 0);
    send(8'h00, 1'b1);
    chk("t1_d2", out_data, 2'b00); chk("t1_s2", out_sat, 0);
    chk("t1_cnt", sat_cnt, 0);

    // Out-of-range words, saturate then wrap.
    send(8'h05, 1'b1);
    chk("t2_d0", out_data, 2'b01); chk("t2_s0", out_sat, 1);
    send(8'h80, 1'b1);
    chk("t2_d1", out_data, 2'b10); chk("t2_s1", out_sat, 1);
    chk("t2_cnt2", sat_cnt, 2);
    send(8'h06, 1'b0);
    chk("t2_d2", out_data, 2'b10); chk("t2_s2", out_sat, 1);
    chk("t2_cnt3", sat_cnt, 3); chk("t2_sticky", sat_sticky, 1);
    step();
    chk("t2_drained", out_valid, 0);

    // Back-pressure: output register then skid fill, third word held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; sat_en = 1'b1;
    step();
    chk("t3_v0", out_valid, 1); chk("t3_d0", out_data, 2'b00); chk("t3_rdy0", in_ready, 1);
    in_data = 8'h01;
    step();
    chk("t3_rdy1", in_ready, 0); chk("t3_hold1", out_data, 2'b00);
    in_data = 8'hFF;
    step();
    chk("t3_rdy2", in_ready, 0); chk("t3_hold2", out_data, 2'b00);
    step();
    chk("t3_hold3", out_data, 2'b00); chk("t3_hv3", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("t3_d1", out_data, 2'b01); chk("t3_rdy3", in_ready, 1); chk("t3_v1", out_valid, 1);
    step();
    chk("t3_d2", out_data, 2'b11); chk("t3_v2", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("t3_empty", out_valid, 0);

    // Counter saturation and clear interactions.
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("t4_clr_cnt", sat_cnt, 0); chk("t4_clr_sticky", sat_sticky, 0);
    in_valid = 1'b1; in_data = 8'h40; sat_en = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("t4_cnt_max", sat_cnt, 255);
    step();
    chk("t4_cnt_hold", sat_cnt, 255);
    clr_stat = 1'b1;
    step();
    chk("t4_clr_ev_cnt", sat_cnt, 1); chk("t4_clr_ev_sticky", sat_sticky, 1);
    in_valid = 1'b0;
    step();
    clr_stat = 1'b0;
    chk("t4_clr_cnt2", sat_cnt, 0); chk("t4_clr_sticky2", sat_sticky, 0);
    step();
    chk("t4_idle", out_valid, 0);

    // Reset with both buffers full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_data = 8'h7F;
    step();
    in_valid = 1'b0;
    chk("t5_full", in_ready, 0); chk("t5_cnt", sat_cnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t5_v", out_valid, 0); chk("t5_rdy", in_ready, 1); chk("t5_cnt0", sat_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_stale", out_valid, 0);
    end

    // Continuous streaming of -8..7 in saturate mode.
    in_valid = 1'b1; sat_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = i - 8;
      in_data = 8'(v);
      step();
      if (v > 1) begin
        exp_d = 2'b01; exp_s = 1'b1;
      end else if (v < -2) begin
        exp_d = 2'b10; exp_s = 1'b1;
      end else begin
        exp_d = 2'(v); exp_s = 1'b0;
      end
      chk("t6_v", out_valid, 1);
      chk("t6_d", out_data, exp_d);
      chk("t6_s", out_sat, exp_s);
      chk("t6_rdy", in_ready, 1);
    end
    in_valid = 1'b0;
    chk("t6_cnt", sat_cnt, 12);
    step();
    chk("t6_end", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
